mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of WAIT cycles without acknowledge before a bus error is declared (legal range 2..31).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port RESET_N, input, 1 bit: synchronous active-low reset.
REQ-004 SHALL have port MR, input, 1 bit: memory-read request from the control state machine, held high until BUSY is seen low.
REQ-005 SHALL have port MW, input, 1 bit: memory-write request, same holding rule as MR; MR and MW are never both high.
REQ-006 SHALL have port ADDR_IN, input, 32 bits: request address.
REQ-007 SHALL have port WDATA_IN, input, 32 bits: store data.
REQ-008 SHALL have port ACK_N, input, 1 bit: active-low memory acknowledge, synchronous to CLK.
REQ-009 SHALL have port BUS_DI, input, 32 bits: read data from memory, valid while ACK_N is low.
REQ-010 SHALL have port AS_N, output, 1 bit: active-low address strobe.
REQ-011 SHALL have port WR_N, output, 1 bit: active-low write strobe; low means write cycle.
REQ-012 SHALL have port ADDR, output, 32 bits: registered bus address.
REQ-013 SHALL have port DO, output, 32 bits: registered bus write data.
REQ-014 SHALL have port RDATA, output, 32 bits: last captured read data.
REQ-015 SHALL have port BUSY, output, 1 bit: stall indication to the control state machine.
REQ-016 SHALL have port BUS_ERR, output, 1 bit: sticky timeout flag.
REQ-017 SHALL have port BUS_STATE, output, 3 bits: current state encoding for debug.

Function
REQ-018 SHALL implement the states IDLE=0, WAIT=1, DONE=2, and ERROR=3.
REQ-019 IDLE: when MR or MW is high and ACK_N=1, SHALL latch ADDR_IN into ADDR, latch WDATA_IN into DO (MW only), latch the direction, clear the timeout counter, and go to WAIT.
REQ-020 IDLE with a request but ACK_N=0 (stale acknowledge) SHALL remain in IDLE with BUSY=1.
REQ-021 WAIT: AS_N SHALL be 0, and WR_N SHALL be 0 for a write or 1 for a read.
REQ-022 WAIT on ACK_N=0 SHALL capture BUS_DI into RDATA (read only) on that edge and go to DONE.
REQ-023 WAIT with ACK_N=1 SHALL increment the counter; when the counter reaches TIMEOUT-1 it SHALL go to ERROR.
REQ-024 DONE SHALL last exactly one cycle with AS_N=1, WR_N=1, and BUSY=0, then go to IDLE.
REQ-025 ERROR SHALL drive AS_N=1, WR_N=1, BUSY=1, and BUS_ERR=1, and SHALL remain in ERROR until reset.
REQ-026 BUSY SHALL be combinational: 1 in WAIT and ERROR, 1 in IDLE while MR or MW is high, 0 in DONE, and 0 in IDLE with no request.
REQ-027 Because BUSY is combinational, BUSY SHALL be high in the same cycle MR/MW first rises, so the requester never sees a false BUSY=0.
REQ-028 DONE SHALL NOT start a new transaction even if MR/MW is still high; the requester drops the request on the following edge.
REQ-029 Minimum latency SHALL be: request cycle (IDLE), then the first WAIT cycle; an ACK_N=0 in the first WAIT cycle yields DONE on the next cycle, i.e. 3 cycles from request to BUSY=0.
REQ-030 A change of MR, MW, or ADDR_IN during WAIT SHALL be ignored; the latched values govern the cycle.
REQ-031 ACK_N=0 in the same cycle the counter reaches TIMEOUT-1 SHALL take priority, going to DONE with no error.

Reset
REQ-032 RESET_N=0 on a clock edge SHALL force IDLE and set AS_N=1, WR_N=1, ADDR=0, DO=0, RDATA=0, BUS_ERR=0, and the counter to 0.
REQ-033 Reset during WAIT SHALL abort the cycle, with AS_N deasserted on that edge and no RDATA update.
REQ-034 Reset SHALL be the only exit from ERROR.

Structure
REQ-035 The state encodings, the bus-state width, and the TIMEOUT default SHALL live in the shared package dlx_bus_pkg, and the control state machine's bus-facing constants SHALL also move there.
REQ-036 The timeout counter SHALL be a sub-module bus_timeout_cnt with clear, enable, terminal-count output, and parameter TIMEOUT.

Verification
REQ-037 A read with ACK_N low 2 cycles into WAIT and BUS_DI=0xDEADBEEF SHALL give RDATA=0xDEADBEEF, a single BUSY=0 pulse (in DONE), and AS_N low for exactly 2 cycles.
REQ-038 A write with ADDR_IN=0x100, WDATA_IN=0x12345678, and ACK in the first WAIT cycle SHALL give WR_N=0 and AS_N=0 for 1 cycle, ADDR=0x100, DO=0x12345678, and RDATA unchanged.
REQ-039 No acknowledge with TIMEOUT=4 SHALL give ERROR after 4 WAIT cycles, with BUS_ERR=1 and BUSY=1 held until RESET_N=0.
REQ-040 ACK_N held low at request time SHALL keep the block in IDLE with BUSY=1; after ACK_N goes high, the transaction SHALL start on the next edge.
REQ-041 RESET_N=0 in the second WAIT cycle SHALL give AS_N=1 on the next cycle, IDLE, and RDATA=0.
REQ-042 A back-to-back fetch, then load, driven by the control-state-machine model SHALL complete both, with 2 DONE pulses and the correct RDATA after each.

Source files
------------

// File: rtl/dlx_bus_pkg.sv
// ---------------------------------------------------------------------------
// dlx_bus_pkg
// Shared definitions for the DLX memory bus:
//   - bus widths seen by the control state machine and the bus controller
//   - bus controller state encoding and its debug width
//   - timeout default and timeout counter width
//   - tc_value(): terminal count for a given TIMEOUT
// ---------------------------------------------------------------------------
package dlx_bus_pkg;

    // Bus-facing widths used by the control state machine and the controller
    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    // Debug state width and default acknowledge timeout
    localparam int BUS_STATE_W = 3;
    localparam int TIMEOUT_DEF = 16;

    // Wide enough for the largest legal TIMEOUT (31)
    localparam int TMO_CNT_W = 5;

    typedef enum logic [BUS_STATE_W-1:0] {
        BS_IDLE  = 3'd0,
        BS_WAIT  = 3'd1,
        BS_DONE  = 3'd2,
        BS_ERROR = 3'd3
    } bus_state_e;

    // The counter starts at 0 in the first WAIT cycle, so reaching
    // TIMEOUT-1 means TIMEOUT WAIT cycles have elapsed without acknowledge.
    function automatic logic [TMO_CNT_W-1:0] tc_value(input int timeout);
        return TMO_CNT_W'(timeout - 1);
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// ---------------------------------------------------------------------------
// bus_timeout_cnt
// Counts WAIT cycles without acknowledge.
// Ports:
//   CLK     : clock, rising edge
//   RESET_N : synchronous active-low reset, clears the count
//   CLR     : synchronous clear (has priority over EN)
//   EN      : advance the count by one
//   TC      : terminal count, high while the count equals TIMEOUT-1
// ---------------------------------------------------------------------------
module bus_timeout_cnt
    import dlx_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)
(
    input  logic CLK,
    input  logic RESET_N,
    input  logic CLR,
    input  logic EN,
    output logic TC
);

    localparam logic [TMO_CNT_W-1:0] TC_VAL = tc_value(TIMEOUT);

    logic [TMO_CNT_W-1:0] cnt_reg;
    logic [TMO_CNT_W-1:0] cnt_next;

    assign TC = (cnt_reg == TC_VAL);

    // Saturate at terminal count so the counter never wraps back below it
    always_comb begin
        cnt_next = cnt_reg;
        if (CLR) begin
            cnt_next = '0;
        end else if (EN && !TC) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl
// Memory bus controller between the DLX control state machine and an
// asynchronous-style memory with an active-low acknowledge.
// Ports:
//   CLK       : clock, rising edge
//   RESET_N   : synchronous active-low reset
//   MR / MW   : read / write request, held until BUSY is seen low
//   ADDR_IN   : request address
//   WDATA_IN  : store data
//   ACK_N     : active-low memory acknowledge (synchronous to CLK)
//   BUS_DI    : read data from memory, valid while ACK_N is low
//   AS_N      : active-low address strobe (low in WAIT)
//   WR_N      : active-low write strobe (low in WAIT for writes)
//   ADDR      : registered bus address
//   DO        : registered bus write data
//   RDATA     : last captured read data
//   BUSY      : combinational stall to the control state machine
//   BUS_ERR   : sticky timeout flag (held in ERROR until reset)
//   BUS_STATE : current state encoding for debug
// ---------------------------------------------------------------------------
module mem_bus_ctrl
    import dlx_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)
(
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   MR,
    input  logic                   MW,
    input  logic [BUS_AW-1:0]      ADDR_IN,
    input  logic [BUS_DW-1:0]      WDATA_IN,
    input  logic                   ACK_N,
    input  logic [BUS_DW-1:0]      BUS_DI,
    output logic                   AS_N,
    output logic                   WR_N,
    output logic [BUS_AW-1:0]      ADDR,
    output logic [BUS_DW-1:0]      DO,
    output logic [BUS_DW-1:0]      RDATA,
    output logic                   BUSY,
    output logic                   BUS_ERR,
    output logic [BUS_STATE_W-1:0] BUS_STATE
);

    bus_state_e        state_reg;
    bus_state_e        state_next;
    logic              dir_write_reg;
    logic [BUS_AW-1:0] addr_reg;
    logic [BUS_DW-1:0] do_reg;
    logic [BUS_DW-1:0] rdata_reg;

    logic accept;
    logic capture;
    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;
    logic busy;
    logic as_n;
    logic wr_n;
    logic req;

    assign req = MR | MW;

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .CLR     (cnt_clr),
        .EN      (cnt_en),
        .TC      (cnt_tc)
    );

    // Next-state and output decode. BUSY follows MR/MW combinationally in
    // IDLE so the requester never samples a false BUSY=0 on its first cycle.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        busy       = 1'b0;
        as_n       = 1'b1;
        wr_n       = 1'b1;
        case (state_reg)
            BS_IDLE: begin
                busy = req;
                // A still-low acknowledge belongs to a previous cycle;
                // hold off until memory releases it.
                if (req && ACK_N) begin
                    accept     = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = BS_WAIT;
                end
            end
            BS_WAIT: begin
                busy = 1'b1;
                as_n = 1'b0;
                wr_n = ~dir_write_reg;
                // Acknowledge wins over the timeout in the same cycle
                if (!ACK_N) begin
                    capture    = ~dir_write_reg;
                    state_next = BS_DONE;
                end else if (cnt_tc) begin
                    state_next = BS_ERROR;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            BS_DONE: begin
                // One-cycle BUSY=0 slot; a still-high request is not restarted
                state_next = BS_IDLE;
            end
            BS_ERROR: begin
                busy = 1'b1;
            end
            default: begin
                state_next = BS_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_reg     <= BS_IDLE;
            dir_write_reg <= 1'b0;
            addr_reg      <= '0;
            do_reg        <= '0;
            rdata_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg      <= ADDR_IN;
                dir_write_reg <= MW;
                if (MW) begin
                    do_reg <= WDATA_IN;
                end
            end
            if (capture) begin
                rdata_reg <= BUS_DI;
            end
        end
    end

    assign AS_N      = as_n;
    assign WR_N      = wr_n;
    assign BUSY      = busy;
    assign BUS_ERR   = (state_reg == BS_ERROR);
    assign BUS_STATE = state_reg;
    assign ADDR      = addr_reg;
    assign DO        = do_reg;
    assign RDATA     = rdata_reg;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_ctrl
// Drives mem_bus_ctrl with a requester that follows the MR/MW hold rule and
// a memory that acknowledges after a chosen number of WAIT cycles. The
// expected bus timeline of every transaction is derived from its parameters
// (stale-ack cycles, ack position, direction), not from the DUT.
// ---------------------------------------------------------------------------
module tb_mem_bus_ctrl;
    import dlx_bus_pkg::*;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        MR;
    logic        MW;
    logic [31:0] ADDR_IN;
    logic [31:0] WDATA_IN;
    logic        ACK_N;
    logic [31:0] BUS_DI;
    logic        AS_N;
    logic        WR_N;
    logic [31:0] ADDR;
    logic [31:0] DO;
    logic [31:0] RDATA;
    logic        BUSY;
    logic        BUS_ERR;
    logic [2:0]  BUS_STATE;

    int n_cmp = 0;
    int n_err = 0;
    int n_txn = 0;

    // Reference view of the registered bus outputs
    logic [31:0] exp_addr;
    logic [31:0] exp_do;
    logic [31:0] exp_rdata;

    always #5 CLK = ~CLK;

    mem_bus_ctrl #(
        .TIMEOUT (TO)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .MR        (MR),
        .MW        (MW),
        .ADDR_IN   (ADDR_IN),
        .WDATA_IN  (WDATA_IN),
        .ACK_N     (ACK_N),
        .BUS_DI    (BUS_DI),
        .AS_N      (AS_N),
        .WR_N      (WR_N),
        .ADDR      (ADDR),
        .DO        (DO),
        .RDATA     (RDATA),
        .BUSY      (BUSY),
        .BUS_ERR   (BUS_ERR),
        .BUS_STATE (BUS_STATE)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_cycle(input string tag, input logic as_n, input logic wr_n,
                               input logic busy, input logic err, input logic [2:0] st);
        check_val({tag, ".as_n"},  {31'd0, AS_N},    {31'd0, as_n});
        check_val({tag, ".wr_n"},  {31'd0, WR_N},    {31'd0, wr_n});
        check_val({tag, ".busy"},  {31'd0, BUSY},    {31'd0, busy});
        check_val({tag, ".err"},   {31'd0, BUS_ERR}, {31'd0, err});
        check_val({tag, ".state"}, {29'd0, BUS_STATE}, {29'd0, st});
    endtask

    task automatic check_regs(input string tag);
        check_val({tag, ".addr"},  ADDR,  exp_addr);
        check_val({tag, ".do"},    DO,    exp_do);
        check_val({tag, ".rdata"}, RDATA, exp_rdata);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        MR      = 1'b0;
        MW      = 1'b0;
        ACK_N   = 1'b1;
        tick();
        RESET_N = 1'b1;
        #1;
        exp_addr  = '0;
        exp_do    = '0;
        exp_rdata = '0;
        check_cycle("reset", 1'b1, 1'b1, 1'b0, 1'b0, 3'(BS_IDLE));
        check_regs("reset");
    endtask

    // One transaction: s stale-ack cycles in IDLE, then k WAIT cycles with
    // ACK_N low in the k-th one. k > TO means memory never answers: TO WAIT
    // cycles, then ERROR until reset. scramble changes ADDR_IN/WDATA_IN in WAIT.
    task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rd, input int k, input int s, input bit scramble);
        n_txn++;
        $display("txn %0d %s addr=%h wdata=%h rdata=%h ack_at=%0d stale=%0d",
                 n_txn, w ? "WR" : "RD", a, d, rd, k, s);
        MR       = ~w;
        MW       = w;
        ADDR_IN  = a;
        WDATA_IN = d;
        BUS_DI   = $urandom;
        for (int c = 0; c < s; c++) begin
            ACK_N = 1'b0;
            #1;
            check_cycle("stale", 1'b1, 1'b1, 1'b1, 1'b0, 3'(BS_IDLE));
            tick();
        end
        ACK_N = 1'b1;
        #1;
        check_cycle("req", 1'b1, 1'b1, 1'b1, 1'b0, 3'(BS_IDLE));
        tick();
        for (int c = 1; c <= TO && c <= k; c++) begin
            ACK_N  = (c == k) ? 1'b0 : 1'b1;
            BUS_DI = (c == k) ? rd : $urandom;
            if (scramble) begin
                ADDR_IN  = $urandom;
                WDATA_IN = $urandom;
            end
            #1;
            check_cycle("wait", 1'b0, ~w, 1'b1, 1'b0, 3'(BS_WAIT));
            check_val("wait.addr", ADDR, a);
            tick();
        end
        exp_addr = a;
        if (w) exp_do = d;
        ACK_N = 1'b1;
        if (k <= TO) begin
            if (!w) exp_rdata = rd;
            #1;
            check_cycle("done", 1'b1, 1'b1, 1'b0, 1'b0, 3'(BS_DONE));
            check_regs("done");
            tick();
            MR = 1'b0;
            MW = 1'b0;
            #1;
            check_cycle("idle", 1'b1, 1'b1, 1'b0, 1'b0, 3'(BS_IDLE));
        end else begin
            for (int c = 0; c < 4; c++) begin
                #1;
                check_cycle("error", 1'b1, 1'b1, 1'b1, 1'b1, 3'(BS_ERROR));
                check_regs("error");
                MR = 1'b0;
                MW = 1'b0;
                tick();
            end
            do_reset();
        end
    endtask

    initial begin
        MR       = 1'b0;
        MW       = 1'b0;
        ACK_N    = 1'b1;
        ADDR_IN  = '0;
        WDATA_IN = '0;
        BUS_DI   = '0;
        RESET_N  = 1'b0;
        tick();
        do_reset();

        // Read acknowledged in the second WAIT cycle
        run_txn(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 2, 0, 1'b0);
        // Write acknowledged in the first WAIT cycle
        run_txn(1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0, 1, 0, 1'b0);
        // Stale acknowledge at request time
        run_txn(1'b0, 32'h0000_0200, 32'h0, 32'h5555_AAAA, 1, 3, 1'b0);
        // Acknowledge exactly at the terminal count
        run_txn(1'b1, 32'h0000_0300, 32'hA5A5_0F0F, 32'h0, TO, 0, 1'b1);

        // Reset in the second WAIT cycle, with an acknowledge pending
        n_txn++;
        $display("txn %0d RD reset in second WAIT cycle", n_txn);
        MR      = 1'b1;
        ADDR_IN = 32'h0000_0400;
        ACK_N   = 1'b1;
        tick();
        #1;
        check_cycle("rst_w1", 1'b0, 1'b1, 1'b1, 1'b0, 3'(BS_WAIT));
        tick();
        RESET_N = 1'b0;
        ACK_N   = 1'b0;
        BUS_DI  = 32'hCAFE_F00D;
        #1;
        check_cycle("rst_w2", 1'b0, 1'b1, 1'b1, 1'b0, 3'(BS_WAIT));
        tick();
        RESET_N = 1'b1;
        MR      = 1'b0;
        ACK_N   = 1'b1;
        exp_addr  = '0;
        exp_do    = '0;
        exp_rdata = '0;
        #1;
        check_cycle("rst_after", 1'b1, 1'b1, 1'b0, 1'b0, 3'(BS_IDLE));
        check_regs("rst_after");

        // Back-to-back fetch then load
        run_txn(1'b0, 32'h0000_1000, 32'h0, 32'h2001_0004, 1, 0, 1'b0);
        run_txn(1'b0, 32'h0000_2008, 32'h0, 32'h0BAD_F00D, 3, 0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    $urandom_range(1, TO), ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b1);
        end

        // No acknowledge: error after TO WAIT cycles, cleared only by reset
        run_txn(1'b0, 32'h0000_3000, 32'h0, 32'h0, TO + 1, 0, 1'b0);
        run_txn(1'b1, 32'h0000_3004, 32'h7777_8888, 32'h0, 1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
